// File: rtl/fifo_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_reader_if
// Groups the FIFO read port and the downstream valid/ready stream used by
// fifo_reader.
//
// Signals:
//   rd        reader -> FIFO    read strobe, single-cycle pulse
//   datout    FIFO -> reader    read data, meaningful when dato=1
//   empy      FIFO -> reader    FIFO empty flag
//   dato      FIFO -> reader    data-valid flag accompanying datout
//   out_data  reader -> sink    head word of the output buffer (0 when empty)
//   out_valid reader -> sink    output buffer non-empty
//   out_ready sink -> reader    sink accepts out_data this cycle
//   busy      reader -> sink    a read is outstanding
//   err       reader -> sink    sticky: dato seen with no read outstanding
//
// Modports:
//   master  the reader side (fifo_reader)
//   slave   the environment side (FIFO plus downstream consumer)
// ---------------------------------------------------------------------------
interface fifo_reader_if #(
  parameter int DW = 3
);
  logic          rd;
  logic [DW-1:0] datout;
  logic          empy;
  logic          dato;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          err;

  modport master (
    output rd, out_data, out_valid, busy, err,
    input  datout, empy, dato, out_ready
  );

  modport slave (
    input  rd, out_data, out_valid, busy, err,
    output datout, empy, dato, out_ready
  );
endinterface

// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
// Read-side consumer for a small FIFO. Issues one read strobe at a time,
// waits for the returned word (dato/datout) with a bounded timer, and
// presents captured words on a valid/ready stream through a 2-entry
// circular output buffer.
//
// Parameters:
//   DW   data width of datout/out_data
//   LAT  nominal FIFO read latency, rd to dato, in rclk cycles (1..3)
//   CW   width of the optional push counter
//
// Ports:
//   rclk    clock, all logic on the rising edge
//   rst     asynchronous active-low reset (0 = reset), released synchronously
//           by the surrounding reset logic
//   bus     fifo_reader_if.master: rd, datout, empy, dato, out_data,
//           out_valid, out_ready, busy, err
//   rd_cnt  (only with FIFO_READER_CNT_EN defined) count of accepted
//           returned words, wraps modulo 2^CW
//
// Optional feature: define FIFO_READER_CNT_EN to add the rd_cnt port and
// its counter. Without it the port and counter are absent and everything
// else behaves identically.
// ---------------------------------------------------------------------------
module fifo_reader #(
  parameter int DW  = 3,
  parameter int LAT = 1,
  parameter int CW  = 8
) (
  input  logic            rclk,
  input  logic            rst,
  fifo_reader_if.master   bus
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [CW-1:0]   rd_cnt
`endif
);

  // Timer must be able to hold LAT+1.
  localparam int TW = $clog2(LAT + 2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            rd_reg, rd_next;
  logic            err_reg;

  logic [DW-1:0]   mem_reg [2];
  logic            wr_ptr_reg;
  logic            rd_ptr_reg;
  logic [1:0]      count_reg;
  logic [1:0]      count_next;
  logic [1:0]      count_eff;

  logic            pop;
  logic            push;
  logic            stray;

  // -------------------------------------------------------------------------
  // Buffer handshake events
  // -------------------------------------------------------------------------
  assign pop   = (count_reg != 2'd0) && bus.out_ready;
  assign push  = (state_reg == WAIT) && bus.dato;
  assign stray = (state_reg == IDLE) && bus.dato;

  // Occupancy as it will be after this cycle's pop; lets the FSM issue a
  // read in the same cycle a full buffer is being drained.
  assign count_eff = count_reg - {1'b0, pop};

  // Push is only possible when a read was issued with a free slot, and only
  // one read is ever outstanding, so count never exceeds 2.
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      rd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      rd_reg    <= rd_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and registered-output inputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    rd_next    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (!bus.empy && (count_eff < 2'd2)) begin
          rd_next    = 1'b1;
          timer_next = '0;
          state_next = WAIT;
        end
      end

      WAIT: begin
        // empy is deliberately ignored here: the word (or the timeout)
        // decides when this read is finished.
        if (bus.dato) begin
          timer_next = '0;
          state_next = IDLE;
        end else if (timer_reg == TW'(LAT)) begin
          // Timer would reach LAT+1 with no data: the FIFO was actually
          // empty when rd was issued (empy lagged). Give up on this read.
          timer_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output buffer storage: one register per entry
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
          mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= bus.datout;
        end
      end
    end
  endgenerate

  // Pointers wrap modulo 2 naturally as 1-bit registers.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error: returned data with no read outstanding is discarded
  // -------------------------------------------------------------------------
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (stray) begin
      err_reg <= 1'b1;
    end
  end

`ifdef FIFO_READER_CNT_EN
  // -------------------------------------------------------------------------
  // Accepted-word counter; timeouts and stray data are not counted
  // -------------------------------------------------------------------------
  logic [CW-1:0] rd_cnt_reg;

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      rd_cnt_reg <= '0;
    end else if (push) begin
      rd_cnt_reg <= rd_cnt_reg + 1'b1;
    end
  end

  assign rd_cnt = rd_cnt_reg;
`endif

  // -------------------------------------------------------------------------
  // Outputs: all derived from registers only
  // -------------------------------------------------------------------------
  assign bus.rd        = rd_reg;
  assign bus.busy      = (state_reg == WAIT);
  assign bus.err       = err_reg;
  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_data  = (count_reg != 2'd0) ? mem_reg[rd_ptr_reg] : '0;

endmodule
